// File: rtl/fifo_tx_serializer_if.sv
// -----------------------------------------------------------------------------
// fifo_tx_serializer_if
//
// Read-side connection between a synchronous FIFO and the serializer that
// consumes it.
//
// Handshake: the consumer raises rd_en for exactly one cycle. It does so only
// after it has sampled empty=0. The FIFO presents the popped word on rdata in
// the following cycle. The consumer keeps at most one read in flight, so no
// ready/valid back-pressure is needed.
//
// Signals:
//   empty  FIFO -> consumer  FIFO holds no words
//   rdata  FIFO -> consumer  registered read data, valid the cycle after rd_en
//   rd_en  consumer -> FIFO  single-cycle read request
//
// Modports:
//   master  serializer side (drives rd_en)
//   slave   FIFO side (drives empty and rdata)
// -----------------------------------------------------------------------------
interface fifo_tx_serializer_if #(
    parameter int WIDTH = 4
);
    logic             empty;
    logic [WIDTH-1:0] rdata;
    logic             rd_en;

    modport master (
        input  empty,
        input  rdata,
        output rd_en
    );

    modport slave (
        output empty,
        output rdata,
        input  rd_en
    );
endinterface

// File: rtl/fifo_tx_serializer.sv
// -----------------------------------------------------------------------------
// fifo_tx_serializer
//
// Pops words one at a time from a synchronous FIFO and sends each word on a
// UART-style line. A frame is a start bit (0), then the data bits LSB first,
// then a stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
//
// Optional feature: define FIFO_TX_PARITY_EN to add an even-parity bit
// between the last data bit and the stop bit.
//
// Ports:
//   clk_i        system clock; all logic runs on the rising edge
//   rst_i        synchronous active-high reset; aborts any frame in progress
//   enable_i     allows a new word to be fetched while the block is idle
//   fifo         FIFO read port (master modport: empty/rdata in, rd_en out)
//   tx_o         serial line; idles high
//   busy_o       high in every state except IDLE
//   frame_cnt_o  count of completed frames; wraps from 255 to 0
//   state_o      current FSM state encoding, for observation
//
// State encoding on state_o:
//   0 IDLE, 1 REQ, 2 CAP, 3 START, 4 DATA, 5 STOP, 6 PAR
// -----------------------------------------------------------------------------
module fifo_tx_serializer #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT) + 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    fifo_tx_serializer_if.master          fifo,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [7:0]                    frame_cnt_o,
    output logic [2:0]                    state_o
);

    localparam int BIT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_CAP   = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
`ifdef FIFO_TX_PARITY_EN
        , S_PAR = 3'd6
`endif
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [WIDTH-1:0]     shift_q;
    logic [BIT_W-1:0]     bit_idx_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [7:0]           frame_cnt_q;
    logic                 period_done;
    logic                 last_bit;

`ifdef FIFO_TX_PARITY_EN
    logic                 parity_q;
`endif

    // The period counter is cleared in CAP, so it starts every bit period at 0.
    assign period_done = (cnt_q == CNT_WIDTH'(CLKS_PER_BIT - 1));
    assign last_bit    = (bit_idx_q == BIT_W'(WIDTH - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // empty is looked at only here, so every fetch follows a
                // non-empty sample.
                if (enable_i && !fifo.empty) begin
                    state_d = S_REQ;
                end
            end
            S_REQ:   state_d = S_CAP;
            S_CAP:   state_d = S_START;
            S_START: begin
                if (period_done) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (period_done && last_bit) begin
`ifdef FIFO_TX_PARITY_EN
                    state_d = S_PAR;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef FIFO_TX_PARITY_EN
            S_PAR: begin
                if (period_done) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (period_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (Moore: state plus registered datapath bits)
    // ------------------------------------------------------------------
    always_comb begin
        tx_o         = 1'b1;
        fifo.rd_en   = 1'b0;
        busy_o       = (state_q != S_IDLE);
        case (state_q)
            S_REQ:   fifo.rd_en = 1'b1;
            S_START: tx_o = 1'b0;
            S_DATA:  tx_o = shift_q[0];
`ifdef FIFO_TX_PARITY_EN
            S_PAR:   tx_o = parity_q;
`endif
            default: tx_o = 1'b1;
        endcase
    end

    assign frame_cnt_o = frame_cnt_q;
    assign state_o     = state_q;

    // ------------------------------------------------------------------
    // Datapath: shift register, bit index, period counter, frame counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q     <= '0;
            bit_idx_q   <= '0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                S_CAP: begin
                    // rdata is valid now, one cycle after the REQ pulse.
                    shift_q   <= fifo.rdata;
                    bit_idx_q <= '0;
                    cnt_q     <= '0;
                end
                S_START: begin
                    cnt_q <= period_done ? '0 : cnt_q + CNT_WIDTH'(1);
                end
                S_DATA: begin
                    if (period_done) begin
                        cnt_q     <= '0;
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= bit_idx_q + BIT_W'(1);
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
`ifdef FIFO_TX_PARITY_EN
                S_PAR: begin
                    cnt_q <= period_done ? '0 : cnt_q + CNT_WIDTH'(1);
                end
`endif
                S_STOP: begin
                    if (period_done) begin
                        cnt_q       <= '0;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

`ifdef FIFO_TX_PARITY_EN
    // Parity is taken from the captured word, because the shift register is
    // consumed while the data bits go out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            parity_q <= 1'b0;
        end else if (state_q == S_CAP) begin
            parity_q <= ^fifo.rdata;
        end
    end
`endif

endmodule

// File: doc/fifo_tx_serializer.md
Name: fifo_tx_serializer

Overview:
- Downstream consumer of the synchronous FIFO. It watches the FIFO's empty flag and pops one word at a time.
- Each popped word is transmitted on a single-wire, UART-style serial line: start bit, data LSB-first, stop bit, with a programmable bit period.
- It sits between the FIFO read port and the chip-level serial output pin.

Parameters:
- WIDTH, 4, data word width; must match the FIFO WIDTH.
- CLKS_PER_BIT, 4, clock cycles per serial bit; must be >= 1.
- CNT_WIDTH, $clog2(CLKS_PER_BIT)+1, width of the bit-period counter.

Ports:
- clk_i  input  1  system clock; all logic is on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- enable_i  input  1  when 1, new words may be fetched from the FIFO.
- fifo_empty_i  input  1  FIFO empty_o.
- fifo_rdata_i  input  WIDTH  FIFO rdata_o; registered, valid the cycle after the read request.
- fifo_rd_en_o  output  1  FIFO read request; single-cycle pulse per word.
- tx_o  output  1  serial line; idles high.
- busy_o  output  1  high in every state except IDLE.
- frame_cnt_o  output  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Reset: one clock with rst_i=1 forces:
  - state=IDLE, tx_o=1, fifo_rd_en_o=0, busy_o=0, frame_cnt_o=0;
  - shift register, bit counter and period counter = 0.
- Reset asserted mid-frame aborts the frame at that edge: tx_o=1 from that edge on, and frame_cnt_o is not incremented.
- All outputs are registered or pure Moore functions of state.
- FSM states: IDLE, REQ, CAP, START, DATA, STOP (plus PAR, see Optional Feature).
- IDLE:
  - tx_o=1.
  - If enable_i=1 and fifo_empty_i=0, go to REQ. Otherwise stay.
- REQ:
  - fifo_rd_en_o=1 for exactly this one cycle; tx_o=1.
  - Always go to CAP.
- CAP:
  - fifo_rdata_i is sampled into the shift register; tx_o=1.
  - Period counter cleared; go to START.
- START:
  - tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx_o=shift[0] for CLKS_PER_BIT cycles.
  - At the end of each bit period: shift right by 1 and increment the bit index.
  - After WIDTH bits, go to STOP (or PAR when enabled).
- STOP:
  - tx_o=1 for CLKS_PER_BIT cycles.
  - On the last cycle, increment frame_cnt_o (mod 256) and go to IDLE.
- Period counter:
  - Counts 0 .. CLKS_PER_BIT-1 and resets to 0 on every bit boundary.
  - With CLKS_PER_BIT=1, each bit lasts exactly one cycle.
- Frame timing:
  - Cycles from leaving IDLE back to IDLE = 2 + (WIDTH+2)*CLKS_PER_BIT.
  - Default frame: 26 cycles.
  - Minimum one IDLE cycle between frames; back-to-back words have a 27-cycle pitch.
- Read-protocol guarantees:
  - fifo_rd_en_o is never asserted while fifo_empty_i=1 was sampled in IDLE.
  - At most one read is in flight at a time, so the FIFO error_o must never be raised by this block.
- enable_i deasserted mid-frame: the current frame completes normally; no new fetch occurs until enable_i=1 again in IDLE.
- fifo_empty_i changes outside IDLE are ignored.

Optional Feature:
- Macro: FIFO_TX_PARITY_EN.
- Defined:
  - PAR state inserted between DATA and STOP.
  - tx_o = even parity (XOR of the captured word) for CLKS_PER_BIT cycles.
  - Frame length becomes 2 + (WIDTH+3)*CLKS_PER_BIT (default 30 cycles).
- Undefined: no PAR state and no parity logic.

Test Plan:
- Reset, then fifo_empty_i=1 and enable_i=1 for 50 cycles -> tx_o=1, fifo_rd_en_o=0, busy_o=0, frame_cnt_o=0 throughout.
- Single word 4'hA (FIFO model with 1-cycle read latency) -> exactly one fifo_rd_en_o pulse.
  - Then tx_o: 0 for 4 cycles, data bits 0,1,0,1 for 4 cycles each, 1 for 4 cycles.
  - frame_cnt_o=1; busy_o high for 26 cycles.
- FIFO loaded with 16 random words, enable_i=1 -> 16 rd_en pulses, 27 cycles apart.
  - Decoded serial words match write order.
  - frame_cnt_o=16; FIFO error_o never 1.
- enable_i dropped during DATA of frame 2 of 5 -> frame 2 completes, no further rd_en pulses, frame_cnt_o=2.
  - Re-enable -> remaining 3 frames sent.
- rst_i pulsed for 1 cycle during DATA -> tx_o=1 at that edge, state=IDLE, frame_cnt_o=0.
  - Next word transmits correctly.
- With FIFO_TX_PARITY_EN, word 4'hB -> parity bit 1 after the data bits; 30-cycle frame.
  - Word 4'h3 -> parity bit 0.
